// File: rtl/tapped_pipe_chain_pkg.sv
// Shared definitions for tapped_pipe_chain: supported depth range, tap index
// type and drop-counter width.
package tapped_pipe_chain_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  // Wide enough to address any stage of the deepest supported chain.
  localparam int TAP_W = $clog2(DEPTH_MAX);
  typedef logic [TAP_W-1:0] tap_t;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/tapped_pipe_chain_pipe_stage.sv
// pipe_stage: single-entry valid/ready register slice. Ready looks through to
// the downstream ready, so a chain of full slices still moves one word per cycle.
module pipe_stage
  import tapped_pipe_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q;
  logic             fire;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign fire        = in_valid_i && in_ready_o;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  // Occupancy: filled by an incoming transfer, emptied when the word leaves.
  always_comb begin
    // NOTE: default first so every path assigns valid_d and no latch is inferred.
    valid_d = valid_q;
    if (fire) begin
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Valid flag register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data register, loaded on every accepted transfer.
  always_ff @(posedge clk) begin
    // NOTE: no reset on payload; valid_q alone decides whether data_q means anything.
    if (fire) begin
      data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/tapped_pipe_chain.sv
// tapped_pipe_chain: chain A is a DEPTH-stage valid/ready pipeline from I to O0.
// Whenever A's tapped stage T hands its word downstream, a copy is offered to
// chain B (DEPTH stages, output O1). B never stalls A: if B's head is full the
// copy is dropped and tap_ovf is set until reset.
// Build option: define TAPPED_PIPE_CHAIN_OVF_CNT_EN to get a saturating drop
// counter on ovf_cnt; otherwise ovf_cnt is tied to zero.
module tapped_pipe_chain
  import tapped_pipe_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAPW  = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O0,
  output logic             O0_valid,
  input  logic             O0_ready,
  output logic [WIDTH-1:0] O1,
  output logic             O1_valid,
  input  logic             O1_ready,
  input  logic [TAPW-1:0]  tap_sel,
  input  logic             tap_load,
  output logic             tap_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  // Depth outside the supported range is pulled back to the nearest bound.
  localparam int D = (DEPTH < DEPTH_MIN) ? DEPTH_MIN :
                     (DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH;
  localparam logic [31:0] D_U = 32'(D);

  logic [WIDTH-1:0] a_data  [D];
  logic             a_valid [D];
  logic [WIDTH-1:0] b_data  [D];
  logic             b_valid [D];

  logic [D-1:0]     tap_hit;
  logic             tap_fire;
  logic [WIDTH-1:0] tap_data;
  logic             drop;

  tap_t             tap_q, tap_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      tap_sel_ext;

  // Ready signals live in per-stage scopes so each stage's ready is its own net.
  for (genvar k = 0; k < D; k++) begin : g_stage
    logic             a_rdy, a_dn_rdy, b_rdy, b_dn_rdy;
    logic [WIDTH-1:0] a_in_d, b_in_d;
    logic             a_in_v, b_in_v;

    if (k == 0) begin : g_head
      assign a_in_d = I;
      assign a_in_v = I_valid;
      assign b_in_d = tap_data;
      assign b_in_v = tap_fire;
    end else begin : g_body
      assign a_in_d = a_data[k-1];
      assign a_in_v = a_valid[k-1];
      assign b_in_d = b_data[k-1];
      assign b_in_v = b_valid[k-1];
    end

    if (k == D - 1) begin : g_tail
      assign a_dn_rdy = O0_ready;
      assign b_dn_rdy = O1_ready;
    end else begin : g_link
      assign a_dn_rdy = g_stage[k+1].a_rdy;
      assign b_dn_rdy = g_stage[k+1].b_rdy;
    end

    // Stage k of A hands its word downstream while it is the active tap.
    assign tap_hit[k] = (tap_q == tap_t'(k)) && a_valid[k] && a_dn_rdy;

    pipe_stage #(.WIDTH(WIDTH)) u_a (
      .clk        (CLK),
      .rst_n      (ASYNCRESETN),
      .in_data_i  (a_in_d),
      .in_valid_i (a_in_v),
      .in_ready_o (a_rdy),
      .out_data_o (a_data[k]),
      .out_valid_o(a_valid[k]),
      .out_ready_i(a_dn_rdy)
    );

    pipe_stage #(.WIDTH(WIDTH)) u_b (
      .clk        (CLK),
      .rst_n      (ASYNCRESETN),
      .in_data_i  (b_in_d),
      .in_valid_i (b_in_v),
      .in_ready_o (b_rdy),
      .out_data_o (b_data[k]),
      .out_valid_o(b_valid[k]),
      .out_ready_i(b_dn_rdy)
    );
  end

  // Select the word leaving the tapped stage; at most one tap_hit bit is set.
  always_comb begin
    tap_data = '0;
    for (int k = 0; k < D; k++) begin
      if (tap_hit[k]) begin
        tap_data = a_data[k];
      end
    end
  end

  assign tap_fire = |tap_hit;
  assign drop     = tap_fire && !g_stage[0].b_rdy;

  assign I_ready  = g_stage[0].a_rdy;
  assign O0       = a_data[D-1];
  assign O0_valid = a_valid[D-1];
  assign O1       = b_data[D-1];
  assign O1_valid = b_valid[D-1];
  assign tap_ovf  = ovf_q;

  // Tap select loads only indices that name an existing stage.
  assign tap_sel_ext = 32'(tap_sel);

  always_comb begin
    tap_d = tap_q;
    if (tap_load && (tap_sel_ext < D_U)) begin
      tap_d = tap_t'(tap_sel);
    end
  end

  assign ovf_d = ovf_q || drop;

  // Active tap and sticky overflow flag.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      tap_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tap_q <= tap_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef TAPPED_PIPE_CHAIN_OVF_CNT_EN
  cnt_t cnt_q, cnt_d;

  assign cnt_d   = drop ? sat_inc(cnt_q) : cnt_q;
  assign ovf_cnt = cnt_q;

  // Saturating count of dropped tap copies.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign ovf_cnt = '0;
`endif

endmodule
